led_pwm_ctrl: RTL

LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

---
 rtl/led_pwm_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM controller with an Avalon-MM register slave.
// Duty values are double-buffered and latched at each PWM period boundary; NUM_LEDS up to 8.
module led_pwm_ctrl #(
  parameter int NUM_LEDS = 8,
  parameter int DUTY_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic [NUM_LEDS-1:0] leds
);

  localparam logic [3:0] ADDR_CTRL     = 4'd8;
  localparam logic [3:0] ADDR_PRESCALE = 4'd9;
  localparam logic [3:0] ADDR_PERIODS  = 4'd10;

  logic [DUTY_W-1:0] duty        [NUM_LEDS];
  logic [DUTY_W-1:0] active_duty [NUM_LEDS];
  logic              en;
  logic              inv;
  logic [15:0]       prescale;
  logic [15:0]       periods;
  logic [15:0]       pre_cnt;
  logic [DUTY_W-1:0] pwm_cnt;

  logic              tick;
  logic              period_end;
  logic [31:0]       rd_mux;

  // Upper write-data bits have no destination in the register map.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:16];

  assign tick       = en && (pre_cnt == prescale);
  assign period_end = tick && (pwm_cnt == '1);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (avs_address == 4'(i)) rd_mux = 32'(duty[i]);
    end
    case (avs_address)
      ADDR_CTRL:     rd_mux = {30'd0, inv, en};
      ADDR_PRESCALE: rd_mux = {16'd0, prescale};
      ADDR_PERIODS:  rd_mux = {16'd0, periods};
      default:       ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the duty arrays are a handful of flops, not RAM, so they are reset explicitly.
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty[i]        <= '0;
        active_duty[i] <= '0;
      end
      en           <= 1'b0;
      inv          <= 1'b0;
      prescale     <= '0;
      periods      <= '0;
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      leds         <= '0;
      avs_readdata <= '0;
    end else begin
      if (avs_write) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (avs_address == 4'(i)) duty[i] <= avs_writedata[DUTY_W-1:0];
        end
        if (avs_address == ADDR_CTRL) begin
          en  <= avs_writedata[0];
          inv <= avs_writedata[1];
        end
        if (avs_address == ADDR_PRESCALE) prescale <= avs_writedata[15:0];
      end

      if (!en) begin
        // Idle: counters parked so enabling starts a fresh period with current duties.
        pre_cnt <= '0;
        pwm_cnt <= '0;
        for (int i = 0; i < NUM_LEDS; i++) active_duty[i] <= duty[i];
      end else begin
        // Free-running 16-bit wrap recovers from a PRESCALE written below pre_cnt.
        pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
        if (tick) pwm_cnt <= pwm_cnt + DUTY_W'(1);
        if (period_end) begin
          for (int i = 0; i < NUM_LEDS; i++) active_duty[i] <= duty[i];
          periods <= periods + 16'd1;
        end
      end

      // A clear write overrides a coincident period increment.
      if (avs_write && (avs_address == ADDR_PERIODS)) periods <= '0;

      for (int i = 0; i < NUM_LEDS; i++) begin
        leds[i] <= (en & (pwm_cnt < active_duty[i])) ^ inv;
      end

      if (avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule
